// File: rtl/branch_resolve_unit_if.sv
// ID-stage branch resolution bundle: operand/forwarding inputs toward the
// resolver, and predictor/redirect/statistics outputs back to the pipeline.
interface branch_resolve_unit_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
);
  logic              iStall;
  logic [1:0]        iBranchOp_D;
  logic              iPredTaken_D;
  logic [DATA_W-1:0] iRsData_D;
  logic [DATA_W-1:0] iRtData_D;
  logic [DATA_W-1:0] iAluOut_E;
  logic [DATA_W-1:0] iWbData_M;
  logic [1:0]        iFU_ASel;
  logic [1:0]        iFU_BSel;
  logic [PC_W-1:0]   iPCplus4_D;
  logic [PC_W-1:0]   iBrTarget_D;
  logic              oPredTaken;
  logic              oFlush_IF;
  logic              oRedirect_Valid;
  logic [PC_W-1:0]   oRedirect_PC;
  logic [CNT_W-1:0]  oBrCnt;
  logic [CNT_W-1:0]  oMispredCnt;
  logic              oLastMispred;

  modport master (
    output iStall, iBranchOp_D, iPredTaken_D, iRsData_D, iRtData_D,
           iAluOut_E, iWbData_M, iFU_ASel, iFU_BSel, iPCplus4_D, iBrTarget_D,
    input  oPredTaken, oFlush_IF, oRedirect_Valid, oRedirect_PC,
           oBrCnt, oMispredCnt, oLastMispred
  );

  modport slave (
    input  iStall, iBranchOp_D, iPredTaken_D, iRsData_D, iRtData_D,
           iAluOut_E, iWbData_M, iFU_ASel, iFU_BSel, iPCplus4_D, iBrTarget_D,
    output oPredTaken, oFlush_IF, oRedirect_Valid, oRedirect_PC,
           oBrCnt, oMispredCnt, oLastMispred
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves beq/bne in ID using forwarded operands, checks the fetch-time
// prediction, redirects IF on mispredict and trains a global 2-bit predictor.
//
// state | meaning
// SNT   | strongly not taken (predict not taken)
// WNT   | weakly not taken   (predict not taken, reset state)
// WT    | weakly taken       (predict taken)
// ST    | strongly taken     (predict taken)
module branch_resolve_unit #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  branch_resolve_unit_if.slave bus
);

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } predState_t;

  predState_t state, nextState;

  logic [DATA_W-1:0] opA, opB;
  logic              isBranch, isBeq, eq, taken, resolve, mispred;
  logic [PC_W-1:0]   redirectPc;
  logic [CNT_W-1:0]  brCnt, mispredCnt;
  logic              lastMispred;

  // Select 11 is unused by the forwarding unit and falls back to the RF read.
  function automatic logic [DATA_W-1:0] fwdMux(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] rfData,
    input logic [DATA_W-1:0] aluData,
    input logic [DATA_W-1:0] wbData
  );
    case (sel)
      2'b10:   return aluData;
      2'b01:   return wbData;
      default: return rfData;
    endcase
  endfunction

  always_comb begin
    opA        = fwdMux(bus.iFU_ASel, bus.iRsData_D, bus.iAluOut_E, bus.iWbData_M);
    opB        = fwdMux(bus.iFU_BSel, bus.iRtData_D, bus.iAluOut_E, bus.iWbData_M);
    eq         = (opA == opB);
    isBeq      = (bus.iBranchOp_D == 2'b01);
    isBranch   = (bus.iBranchOp_D == 2'b01) || (bus.iBranchOp_D == 2'b10);
    taken      = isBranch && (isBeq ? eq : !eq);
    resolve    = isBranch && !bus.iStall;
    mispred    = resolve && (taken != bus.iPredTaken_D);
    redirectPc = taken ? bus.iBrTarget_D : bus.iPCplus4_D;
  end

  assign bus.oFlush_IF       = mispred;
  assign bus.oRedirect_Valid = mispred;
  assign bus.oRedirect_PC    = redirectPc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WNT;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    if (resolve) begin
      if (taken) begin
        case (state)
          SNT:     nextState = WNT;
          WNT:     nextState = WT;
          default: nextState = ST;
        endcase
      end else begin
        case (state)
          ST:      nextState = WT;
          WT:      nextState = WNT;
          default: nextState = SNT;
        endcase
      end
    end
  end

  // Registered state only: the prediction never sees the resolve in flight.
  assign bus.oPredTaken = state[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brCnt       <= '0;
      mispredCnt  <= '0;
      lastMispred <= 1'b0;
    end else if (resolve) begin
      if (brCnt != '1) begin
        brCnt <= brCnt + CNT_W'(1);
      end
      if (mispred && (mispredCnt != '1)) begin
        mispredCnt <= mispredCnt + CNT_W'(1);
      end
      lastMispred <= mispred;
    end
  end

  assign bus.oBrCnt       = brCnt;
  assign bus.oMispredCnt  = mispredCnt;
  assign bus.oLastMispred = lastMispred;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized and directed bench for branch_resolve_unit against an
// arithmetic reference model (narrow statistics counters to reach saturation).
module tb_branch_resolve_unit;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int CNT_W  = 6;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  branch_resolve_unit_if #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  branch_resolve_unit #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: predictor as a saturating 0..3 integer, counts as ints.
  int predCtr = 1;
  int brCnt   = 0;
  int misCnt  = 0;
  bit lastMis = 1'b0;
  bit lastTaken, lastResolve;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pick(input logic [1:0] sel, input logic [DATA_W-1:0] rf,
                                             input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] wb);
    if (sel == 2'b10) return alu;
    if (sel == 2'b01) return wb;
    return rf;
  endfunction

  function automatic logic [DATA_W-1:0] rv();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return DATA_W'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  task automatic modelReset();
    predCtr = 1;
    brCnt   = 0;
    misCnt  = 0;
    lastMis = 1'b0;
  endtask

  // Entered at posedge+1; leaves at the next posedge+1.
  task automatic step(input logic [1:0] op, input bit pred, input logic [DATA_W-1:0] rs,
                      input logic [DATA_W-1:0] rt, input logic [DATA_W-1:0] alu,
                      input logic [DATA_W-1:0] wb, input logic [1:0] aSel, input logic [1:0] bSel,
                      input bit stall, input logic [PC_W-1:0] pc4, input logic [PC_W-1:0] tgt);
    logic [DATA_W-1:0] a, b;
    bit isBr, tk, res, mis;
    bus.iBranchOp_D  = op;
    bus.iPredTaken_D = pred;
    bus.iRsData_D    = rs;
    bus.iRtData_D    = rt;
    bus.iAluOut_E    = alu;
    bus.iWbData_M    = wb;
    bus.iFU_ASel     = aSel;
    bus.iFU_BSel     = bSel;
    bus.iStall       = stall;
    bus.iPCplus4_D   = pc4;
    bus.iBrTarget_D  = tgt;
    #2;
    a    = pick(aSel, rs, alu, wb);
    b    = pick(bSel, rt, alu, wb);
    isBr = (op == 2'd1) || (op == 2'd2);
    tk   = isBr && ((op == 2'd1) ? (a == b) : (a != b));
    res  = isBr && !stall;
    mis  = res && (tk != pred);
    chk("flush", bus.oFlush_IF, mis);
    chk("redirValid", bus.oRedirect_Valid, mis);
    if (mis) chk("redirPC", bus.oRedirect_PC, tk ? tgt : pc4);
    chk("predPre", bus.oPredTaken, predCtr >= 2);
    @(posedge clk);
    #1;
    if (res) begin
      predCtr = tk ? ((predCtr < 3) ? predCtr + 1 : 3) : ((predCtr > 0) ? predCtr - 1 : 0);
      brCnt   = (brCnt < CMAX) ? brCnt + 1 : CMAX;
      if (mis) misCnt = (misCnt < CMAX) ? misCnt + 1 : CMAX;
      lastMis = mis;
    end
    lastTaken   = tk;
    lastResolve = res;
    chk("predPost", bus.oPredTaken, predCtr >= 2);
    chk("brCnt", bus.oBrCnt, brCnt);
    chk("misCnt", bus.oMispredCnt, misCnt);
    chk("lastMis", bus.oLastMispred, lastMis);
  endtask

  task automatic doReset();
    #2 rst_n = 1'b0;
    modelReset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic randStep(input bit forceBranch);
    logic [1:0] op;
    logic [DATA_W-1:0] rs, rt;
    op = forceBranch ? 2'($urandom_range(1, 2)) : 2'($urandom_range(0, 3));
    rs = rv();
    rt = ($urandom_range(0, 2) == 0) ? rs : rv();
    step(op, 1'($urandom_range(0, 1)), rs, rt, rv(), rv(),
         2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
         forceBranch ? 1'b0 : ($urandom_range(0, 4) == 0), $urandom, $urandom);
  endtask

  initial begin
    int cntBefore;
    bus.iStall = 1'b0;  bus.iBranchOp_D = 2'd0; bus.iPredTaken_D = 1'b0;
    bus.iRsData_D = '0; bus.iRtData_D = '0; bus.iAluOut_E = '0; bus.iWbData_M = '0;
    bus.iFU_ASel = 2'd0; bus.iFU_BSel = 2'd0; bus.iPCplus4_D = '0; bus.iBrTarget_D = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rstPred", bus.oPredTaken, 1'b0);
    chk("rstBrCnt", bus.oBrCnt, 0);
    chk("rstMisCnt", bus.oMispredCnt, 0);
    chk("rstLast", bus.oLastMispred, 1'b0);

    // beq equal operands, predicted not taken -> mispredict to target
    step(2'd1, 1'b0, 32'h5, 32'h5, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 32'h104, 32'h100);
    chk("t1Pred", bus.oPredTaken, 1'b1);
    chk("t1BrCnt", bus.oBrCnt, 1);
    chk("t1Last", bus.oLastMispred, 1'b1);

    // forwarding: EX result makes operands equal; then MEM result makes them differ
    step(2'd2, 1'b1, 32'h1, 32'h7, 32'h7, 32'h0, 2'd2, 2'd0, 1'b0, 32'h204, 32'h300);
    chk("fwdExTaken", lastTaken, 1'b0);
    step(2'd2, 1'b1, 32'h1, 32'h7, 32'h7, 32'h3, 2'd1, 2'd0, 1'b0, 32'h204, 32'h300);
    chk("fwdMemNoMis", bus.oLastMispred, 1'b0);

    // predictor saturation from reset
    doReset();
    for (int i = 0; i < 4; i++)
      step(2'd1, 1'b1, 32'h9, 32'h9, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 32'h10, 32'h20);
    step(2'd1, 1'b1, 32'h9, 32'h8, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 32'h10, 32'h20);
    chk("satPredAfterNT", bus.oPredTaken, 1'b1);

    // stall hold: resolves exactly once
    cntBefore = brCnt;
    for (int i = 0; i < 3; i++)
      step(2'd1, 1'b0, 32'h4, 32'h4, 32'h0, 32'h0, 2'd0, 2'd0, 1'b1, 32'h44, 32'h80);
    step(2'd1, 1'b0, 32'h4, 32'h4, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 32'h44, 32'h80);
    chk("stallOnce", bus.oBrCnt, cntBefore + 1);

    for (int i = 0; i < 300; i++) randStep(1'b0);

    // counter saturation at all-ones
    for (int i = 0; i < CMAX + 3; i++) randStep(1'b1);
    chk("brCntSat", bus.oBrCnt, CMAX);

    // async reset between edges with predictor strong-taken and counts non-zero
    for (int i = 0; i < 3; i++)
      step(2'd2, 1'b1, 32'h1, 32'h2, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 32'h4, 32'h8);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    chk("arstPred", bus.oPredTaken, 1'b0);
    chk("arstBrCnt", bus.oBrCnt, 0);
    chk("arstMisCnt", bus.oMispredCnt, 0);
    chk("arstLast", bus.oLastMispred, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 100; i++) randStep(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- ID-stage consumer of the forwarding unit's operand selects for the BrPred pipeline.
- Applies the forwarding selects to produce the Rs/Rt operands and compares them for beq/bne.
- Resolves the branch in ID and keeps a global 2-bit saturating predictor that feeds IF.
- Checks the prediction carried in IF/ID and drives the IF flush, PC redirect, and branch/mispredict statistics counters.

Parameters:
DATA_W, 32, operand width
PC_W, 32, program counter width
CNT_W, 16, statistics counter width

Ports:
clk  input  1  pipeline clock
rst_n  input  1  asynchronous active-low reset
iStall  input  1  ID stage held by hazard unit this cycle
iBranchOp_D  input  2  00 none, 01 beq, 10 bne, 11 reserved (treated as none)
iPredTaken_D  input  1  prediction made at fetch for the instruction now in ID
iRsData_D  input  DATA_W  register-file Rs read data
iRtData_D  input  DATA_W  register-file Rt read data
iAluOut_E  input  DATA_W  EX-stage result (forward select 10)
iWbData_M  input  DATA_W  MEM-stage result (forward select 01)
iFU_ASel  input  2  Rs operand select from the forwarding unit
iFU_BSel  input  2  Rt operand select from the forwarding unit
iPCplus4_D  input  PC_W  fall-through PC of the ID instruction
iBrTarget_D  input  PC_W  branch target of the ID instruction
oPredTaken  output  1  current predictor output for IF (state[1])
oFlush_IF  output  1  squash the IF/ID instruction
oRedirect_Valid  output  1  load oRedirect_PC into the PC next edge
oRedirect_PC  output  PC_W  corrected PC
oBrCnt  output  CNT_W  resolved-branch count
oMispredCnt  output  CNT_W  mispredict count
oLastMispred  output  1  registered: the previous resolution mispredicted

Behaviour:
- Operand mux:
  - select 00 -> register-file data; 10 -> iAluOut_E; 01 -> iWbData_M; 11 -> register-file data.
  - Applied identically to A/Rs (iFU_ASel) and B/Rt (iFU_BSel).
- Compare and resolve:
  - eq = (opA == opB) over the full DATA_W bits.
  - taken = (beq & eq) | (bne & ~eq).
  - resolve = (iBranchOp_D is 01 or 10) & ~iStall.
  - mispred = resolve & (taken != iPredTaken_D).
- Combinational outputs, same cycle as resolve:
  - oFlush_IF = mispred; oRedirect_Valid = mispred.
  - oRedirect_PC = taken ? iBrTarget_D : iPCplus4_D; this value is don't-care when oRedirect_Valid = 0.
  - No latency beyond the comparator path.
- Predictor FSM, 2 bits, states SNT=00, WNT=01, WT=10, ST=11:
  - Updates only on a clk edge where resolve = 1.
  - taken -> increment, saturating at ST; not taken -> decrement, saturating at SNT.
  - oPredTaken = state[1], registered state only, never bypassed from the current resolve.
- Counters, on a resolve edge:
  - oBrCnt += 1.
  - oMispredCnt += 1 when mispred.
  - Both saturate at all-ones and never wrap.
- oLastMispred: loads mispred on every resolve edge; holds otherwise.
- Stall:
  - iStall = 1 suppresses resolve entirely: no flush, no redirect, no FSM or counter update.
  - A branch held for N cycles resolves exactly once, in the first cycle iStall = 0.
- Reset (rst_n low, asynchronous, at any time including mid-resolve):
  - FSM = WNT (oPredTaken = 0); oBrCnt = 0, oMispredCnt = 0, oLastMispred = 0.
  - Combinational outputs follow their inputs and are not gated by reset.
- Non-branch or reserved op: no state change; oFlush_IF = 0; oRedirect_Valid = 0.

Test Plan:
- Reset then beq, rs=rt=0x5, both selects 00, iPredTaken_D=0 -> oFlush_IF=1, oRedirect_PC=iBrTarget_D (0x100); next cycle FSM=WT, oPredTaken=1, oBrCnt=1, oMispredCnt=1, oLastMispred=1.
- Forwarding priority: bne, iRsData_D=1, iAluOut_E=7, iRtData_D=7, iFU_ASel=10, iFU_BSel=00, pred=1 -> eq, not taken, mispred=1, oRedirect_PC=iPCplus4_D; repeat with iFU_ASel=01, iWbData_M=3 -> taken, no flush.
- Saturation: 4 consecutive taken beq resolves from reset -> state WNT->WT->ST->ST; oPredTaken stays 1 after the 1st; then 1 not-taken -> WT, oPredTaken still 1.
- Stall hold: beq with iStall=1 for 3 cycles, then iStall=0 -> oFlush_IF asserted only in the final cycle; oBrCnt increments by exactly 1.
- Counter saturation: preload oBrCnt to 0xFFFE via 65534 resolves (or forced), 3 more resolves -> oBrCnt=0xFFFF, no wrap.
- Async reset mid-resolve: rst_n low between edges with FSM=ST, counts non-zero -> immediately oPredTaken=0, counts 0, oLastMispred=0 without waiting for clk.
